shift_seq_ctrl: RTL and testbench
=================================

Name: shift_seq_ctrl

Overview:
Command-driven sequencer for a WIDTH-bit shift register advanced on a programmable time base.
- Requester issues one command (op, step count, load data) over a valid/ready handshake.
- Controller runs the requested number of shift/rotate steps, one per tick period, then pulses done.
- Sits between a host/FSM and the LED/display-style shift datapath; replaces free-running shifters with a sequenced, bounded one.

Parameters:
WIDTH, 4, shift register width in bits (>=2)
TIME, 50000000, tick period in clk cycles (>=2)
CNT_W, 26, tick counter width; must hold TIME-1
LEN_W, 4, step-count field width

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept command (high only in IDLE)
cmd_op  input  2  00 serial shift-left with ser_in into bit 0; 01 rotate left; 10 rotate right; 11 parallel load
cmd_len  input  LEN_W  number of steps for ops 00/01/10; ignored for op 11
cmd_data  input  WIDTH  load value for op 11
ser_in  input  1  serial input bit, sampled at each tick step
out  output  WIDTH  shift register contents
busy  output  1  high in RUN
tick  output  1  one-cycle pulse when a step executes
done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; out=0, tick counter=0, step counter=0, busy=0, tick=0, done=0; cmd_ready=1 from first cycle after reset. Reset mid-command aborts it with no done pulse.
- Handshake: accept when cmd_valid && cmd_ready on a clk edge. Fields latched at accept; later changes to cmd_* ignored. cmd_ready=0 outside IDLE. Requester may hold cmd_valid; nothing accepted until IDLE.
- States: IDLE, RUN, DONE.
- IDLE -> RUN on accept with op in {00,01,10} and cmd_len!=0. Tick counter cleared to 0; step counter loaded with cmd_len.
- IDLE -> DONE on accept with op 11: out<=cmd_data at the accept edge; no tick pulse.
- IDLE -> DONE on accept with cmd_len==0 (ops 00/01/10): out unchanged, no tick.
- RUN: tick counter increments each cycle. When it equals TIME-1: counter wraps to 0, one step executes, tick=1 for that cycle, step counter decrements.
  - First step executes TIME cycles after accept; subsequent steps every TIME cycles.
- Step ops:
  - 00: out<={out[WIDTH-2:0], ser_in}, with ser_in sampled at the step edge.
  - 01: out<={out[WIDTH-2:0], out[WIDTH-1]}.
  - 10: out<={out[0], out[WIDTH-1:1]}.
- RUN -> DONE on the edge executing the final step (step counter 1 -> 0).
- DONE: done=1 for exactly one cycle; then IDLE, cmd_ready=1.
- Back-to-back commands: minimum 2 cycles between a final step and the next accept (DONE, then IDLE).
- Total latency, op 00/01/10, len N: done asserted N*TIME+1 cycles after the accept edge.
- out holds its value in IDLE and DONE. Counter arithmetic is unsigned, with no overflow beyond TIME-1.

Optional Feature:
SHIFT_SEQ_CTRL_ABORT_EN
- Defined: adds input abort (1 bit).
  - abort=1 in RUN -> next state DONE, remaining steps dropped, out keeps current value, done pulses, tick counter cleared.
  - If abort coincides with a step edge, the step still executes.
  - abort is ignored in IDLE/DONE.
- Not defined: no abort port; RUN always runs to cmd_len steps.

Test Plan:
- Reset: hold rst=1 for 3 cycles with cmd_valid=1 -> out=0, busy=0, done=0, no accept; cmd_ready=1 the cycle after rst falls.
- TIME=4, WIDTH=4: load 4'b1001 (op 11), then rotate left len 3 -> out 0011, 0110, 1100 at ticks 4, 8, 12 cycles after accept; done at cycle 13.
- Serial shift: out=0, op 00 len 4, ser_in=1,0,1,1 at successive ticks -> out=4'b1011, 4 tick pulses, one done.
- Rotate right len 0 -> no tick, out unchanged, done 1 cycle after accept. Next command with cmd_valid held during RUN -> not accepted until IDLE.
- rst=1 mid-RUN after 1 of 3 steps -> out=0, no done, cmd_ready=1 next cycle.
- ABORT_EN: abort during rotate len 5 after 2 steps -> done pulses, out holds 2-step value, no further ticks.

Source files
------------

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: accepts one shift/rotate/load command and steps a WIDTH-bit register once every TIME clocks.
// Define SHIFT_SEQ_CTRL_ABORT_EN to add an abort input that ends a running command early.
module shift_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int TIME  = 50000000,
  parameter int CNT_W = 26,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             ser_in,
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tick,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIME - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_steps;
  logic [1:0]       r_op;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;
  logic             r_ready;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_out_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LEN_W-1:0] w_steps_nxt;
  logic [1:0]       w_op_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out;
    w_cnt_nxt   = r_cnt;
    w_steps_nxt = r_steps;
    w_op_nxt    = r_op;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_op_nxt    = cmd_op;
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_steps_nxt = cmd_len;
          if (cmd_op == 2'b11) begin
            w_out_nxt   = cmd_data;
            w_state_nxt = S_DONE;
          end else if (cmd_len == {LEN_W{1'b0}}) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_nxt   = {CNT_W{1'b0}};
          w_steps_nxt = r_steps - LEN_W'(1);
          case (r_op)
            2'b00:   w_out_nxt = {r_out[WIDTH-2:0], ser_in};
            2'b01:   w_out_nxt = {r_out[WIDTH-2:0], r_out[WIDTH-1]};
            2'b10:   w_out_nxt = {r_out[0], r_out[WIDTH-1:1]};
            default: w_out_nxt = r_out;
          endcase
          if (r_steps == LEN_W'(1)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RUN;
          end
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
        // A step due on the abort edge still lands; only the remaining steps are dropped.
        if (abort) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else begin
          w_cnt_nxt = w_cnt_nxt;
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Status flags are registered from the next state so each one is high during the
  // cycle it describes (tick in the cycle whose closing edge performs the step).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_out   <= {WIDTH{1'b0}};
      r_cnt   <= {CNT_W{1'b0}};
      r_steps <= {LEN_W{1'b0}};
      r_op    <= 2'b00;
      r_tick  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_out   <= w_out_nxt;
      r_cnt   <= w_cnt_nxt;
      r_steps <= w_steps_nxt;
      r_op    <= w_op_nxt;
      r_tick  <= (w_state_nxt == S_RUN) && (w_cnt_nxt == CNT_LAST);
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt == S_DONE);
      r_ready <= (w_state_nxt == S_IDLE);
    end
  end

  assign cmd_ready = r_ready;
  assign out       = r_out;
  assign busy      = r_busy;
  assign tick      = r_tick;
  assign done      = r_done;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl (WIDTH=4, TIME=4): command table plus reset/hold/abort sequences.
module tb_shift_seq_ctrl;
  localparam int WIDTH = 4;
  localparam int TIME  = 4;
  localparam int CNT_W = 3;
  localparam int LEN_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [1:0]       cmd_op = 2'b00;
  logic [LEN_W-1:0] cmd_len = 4'd0;
  logic [WIDTH-1:0] cmd_data = 4'd0;
  logic             ser_in = 1'b0;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             tick;
  logic             done;
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
  logic             abort = 1'b0;
`endif

  shift_seq_ctrl #(.WIDTH(WIDTH), .TIME(TIME), .CNT_W(CNT_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data), .ser_in(ser_in),
`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    .abort(abort),
`endif
    .out(out), .busy(busy), .tick(tick), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [LEN_W-1:0] len;
    logic [WIDTH-1:0] data;
    logic [15:0]      ser;
    logic [WIDTH-1:0] exp_out;
    int               exp_ticks;
    int               exp_lat;
  } vec_t;

  vec_t vecs[10];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency is counted in edges after the accept edge; done must be high at edge exp_lat.
  task automatic run_cmd(input vec_t v, input int idx);
    int ticks;
    int lat;
    @(negedge clk);
    check($sformatf("v%0d.ready", idx), cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_len = v.len; cmd_data = v.data; ser_in = v.ser[0];
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = ~v.op; cmd_len = ~v.len; cmd_data = ~v.data;
    ticks = 0;
    lat = 0;
    for (int cyc = 1; cyc <= 100; cyc++) begin
      if (cyc > 1) @(negedge clk);
      ser_in = (ticks < 16) ? v.ser[ticks] : 1'b0;
      if (cyc == 1) check($sformatf("v%0d.busy", idx), busy, (v.exp_lat > 1) ? 1 : 0);
      if (tick) begin
        ticks++;
        check($sformatf("v%0d.tick_cyc", idx), cyc, ticks * TIME);
      end
      if (done) begin
        lat = cyc;
        break;
      end
    end
    check($sformatf("v%0d.latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d.ticks", idx), ticks, v.exp_ticks);
    check($sformatf("v%0d.out", idx), out, v.exp_out);
    @(negedge clk);
    check($sformatf("v%0d.done_once", idx), done, 0);
    check($sformatf("v%0d.ready_after", idx), cmd_ready, 1);
  endtask

  initial begin
    int seen;
    int n_tick;
    int n_done;
    vecs[0] = '{2'b11, 4'd0,  4'b1001, 16'h0000, 4'b1001, 0,  1};
    vecs[1] = '{2'b01, 4'd3,  4'b0000, 16'h0000, 4'b1100, 3,  13};
    vecs[2] = '{2'b10, 4'd0,  4'b1111, 16'h0000, 4'b1100, 0,  1};
    vecs[3] = '{2'b10, 4'd1,  4'b0000, 16'h0000, 4'b0110, 1,  5};
    vecs[4] = '{2'b11, 4'd7,  4'b0000, 16'h0000, 4'b0000, 0,  1};
    vecs[5] = '{2'b00, 4'd4,  4'b0000, 16'h000D, 4'b1011, 4,  17};
    vecs[6] = '{2'b01, 4'd4,  4'b0000, 16'h0000, 4'b1011, 4,  17};
    vecs[7] = '{2'b10, 4'd2,  4'b0000, 16'h0000, 4'b1110, 2,  9};
    vecs[8] = '{2'b00, 4'd15, 4'b0000, 16'h0000, 4'b0000, 15, 61};
    vecs[9] = '{2'b11, 4'd5,  4'b1010, 16'h0000, 4'b1010, 0,  1};

    // Reset held with a pending load: nothing may be accepted.
    rst = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b11; cmd_data = 4'b1111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.out", out, 0);
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    rst = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    check("rst.ready", cmd_ready, 1);
    check("rst.no_accept", out, 0);

    for (int i = 0; i < 10; i++) run_cmd(vecs[i], i);

    // Command held valid through a run is only taken once the controller is back in IDLE.
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd2;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 2'b11; cmd_data = 4'b1111;
    seen = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (cyc > 1) @(negedge clk);
      if (cyc == 5) begin
        check("hold.ready_low", cmd_ready, 0);
        check("hold.busy", busy, 1);
      end
      if (cmd_ready) begin
        seen = cyc;
        break;
      end
    end
    check("hold.ready_cyc", seen, 2 * TIME + 2);
    check("hold.out_before", out, 4'b1010);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("hold.load_done", done, 1);
    check("hold.load_out", out, 4'b1111);

    // Reset during a run aborts it silently.
    run_cmd('{2'b11, 4'd0, 4'b0001, 16'h0000, 4'b0001, 0, 1}, 10);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd3;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      if (tick) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("mrst.one_step", out, 4'b0010);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst.out", out, 0);
    check("mrst.busy", busy, 0);
    check("mrst.done", done, 0);
    check("mrst.ready", cmd_ready, 1);
    n_tick = 0; n_done = 0;
    for (int cyc = 0; cyc < 3 * TIME; cyc++) begin
      @(negedge clk);
      if (tick) n_tick++;
      if (done) n_done++;
    end
    check("mrst.no_tick", n_tick, 0);
    check("mrst.no_done", n_done, 0);

`ifdef SHIFT_SEQ_CTRL_ABORT_EN
    // Abort after two of five rotate steps keeps the two-step value.
    run_cmd('{2'b11, 4'd0, 4'b0001, 16'h0000, 4'b0001, 0, 1}, 11);
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_len = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n_tick = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (tick) n_tick++;
      if (n_tick == 2) break;
      @(negedge clk);
    end
    @(negedge clk);
    check("abort.pre_out", out, 4'b0100);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort.done", done, 1);
    check("abort.out", out, 4'b0100);
    check("abort.busy", busy, 0);
    n_tick = 0; n_done = 0;
    for (int cyc = 0; cyc < 3 * TIME; cyc++) begin
      @(negedge clk);
      if (tick) n_tick++;
      if (done) n_done++;
    end
    check("abort.no_tick", n_tick, 0);
    check("abort.no_done", n_done, 0);
    check("abort.out_hold", out, 4'b0100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

endmodule
